// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory request/response side plus the decode-facing valid/ready side.
// Latency: none, wires only.
// Backpressure: carried by instr_gnt_i (memory) and f2d_ready_i (decode); master = fetch stage.
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fetch_en_i;
  logic              instr_req_o;
  logic [ADDR_W-1:0] instr_addr_o;
  logic              instr_gnt_i;
  logic              instr_rvalid_i;
  logic [DATA_W-1:0] instr_rdata_i;
  logic              instr_err_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_addr_i;
  logic              f2d_valid_o;
  logic              f2d_ready_i;
  logic [ADDR_W-1:0] f2d_pc_o;
  logic [DATA_W-1:0] f2d_instr_o;
  logic              f2d_err_o;
  logic              busy_o;

  modport master (
    input  fetch_en_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
           redirect_i, redirect_addr_i, f2d_ready_i,
    output instr_req_o, instr_addr_o, f2d_valid_o, f2d_pc_o, f2d_instr_o, f2d_err_o, busy_o
  );

  modport slave (
    output fetch_en_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
           redirect_i, redirect_addr_i, f2d_ready_i,
    input  instr_req_o, instr_addr_o, f2d_valid_o, f2d_pc_o, f2d_instr_o, f2d_err_o, busy_o
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Sequential instruction fetch with up to MAX_OUTST requests in flight, responses buffered in a DEPTH FIFO.
// Latency: rvalid in cycle N -> f2d_valid_o in N+1; one request per cycle peak.
// Backpressure: requests issue only while FIFO entries + in-flight < DEPTH, so decode stalls never drop data.
module if_fetch_queue #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = ADDR_W'(32'h80)
) (
  input logic               clk_i,
  input logic               rst_i,
  if_fetch_queue_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int SW = $clog2(DEPTH + MAX_OUTST + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HALT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              err;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pending_q, pending_d;   // request asserted last cycle and not granted
  logic              stale_q, stale_d;       // held request belongs to the pre-redirect stream
  logic [ADDR_W-1:0] restart_q, restart_d;   // where to resume once a stale request is granted
  logic [OW-1:0]     outst_q, outst_d;
  logic [OW-1:0]     discard_q, discard_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic [QW-1:0]     pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];
  logic [ADDR_W-1:0] pcq_q [MAX_OUTST];
  logic [ADDR_W-1:0] pcq_d [MAX_OUTST];

  logic              req, req_new, gnt_fire, hold_req, rv, drop, push, pop, redir, rsp_err;
  logic [ADDR_W-1:0] redir_addr;
  entry_t            head, push_ent;

  // Handshake decode: request eligibility, grant, response routing, pop.
  always_comb begin
    redir      = bus.redirect_i;
    redir_addr = {bus.redirect_addr_i[ADDR_W-1:2], 2'b00};
    req_new    = (state_q == ST_FETCH) && bus.fetch_en_i
                 && ((SW'(count_q) + SW'(outst_q)) < SW'(DEPTH))
                 && (outst_q < OW'(MAX_OUTST));
    req        = pending_q || req_new;
    gnt_fire   = req && bus.instr_gnt_i;
    hold_req   = req && !bus.instr_gnt_i;
    rv         = bus.instr_rvalid_i;
    rsp_err    = bus.instr_err_i;
    drop       = rv && (discard_q != '0);
    push       = rv && !drop && !redir;
    pop        = (count_q != '0) && bus.f2d_ready_i && !redir;
    push_ent   = '{pc: pcq_q[pq_rd_q], instr: bus.instr_rdata_i, err: rsp_err};
    head       = fifo_q[rd_q];
  end

  assign bus.instr_req_o  = req;
  assign bus.instr_addr_o = addr_q;
  assign bus.f2d_valid_o  = (count_q != '0);
  assign bus.f2d_pc_o     = (count_q != '0) ? head.pc    : '0;
  assign bus.f2d_instr_o  = (count_q != '0) ? head.instr : '0;
  assign bus.f2d_err_o    = (count_q != '0) && head.err;
  assign bus.busy_o       = (outst_q != '0) || (count_q != '0);

  // Fetch FSM: idle / fetching / halted on error; redirect always restarts fetching.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (push && rsp_err)      state_d = ST_HALT;
        else if (bus.fetch_en_i)  state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (push && rsp_err)                  state_d = ST_HALT;
        else if (!bus.fetch_en_i && !hold_req) state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (redir) state_d = ST_FETCH;
  end

  // Address sequencing, in-flight/discard accounting and the response-order PC queue.
  always_comb begin
    addr_d    = addr_q;
    pending_d = hold_req;
    stale_d   = stale_q;
    restart_d = restart_q;
    outst_d   = outst_q + OW'(gnt_fire) - OW'(rv);
    discard_d = discard_q;
    pq_wr_d   = pq_wr_q;
    pq_rd_d   = pq_rd_q;
    pcq_d     = pcq_q;

    if (gnt_fire) begin
      pcq_d[pq_wr_q] = addr_q;
      pq_wr_d = (pq_wr_q == QW'(MAX_OUTST - 1)) ? '0 : pq_wr_q + QW'(1);
    end
    if (rv) pq_rd_d = (pq_rd_q == QW'(MAX_OUTST - 1)) ? '0 : pq_rd_q + QW'(1);

    if (redir) begin
      // Everything granted up to and including this cycle is dropped on return;
      // an ungranted request must still complete at its old address, then gets dropped.
      discard_d = outst_d;
      restart_d = redir_addr;
      if (hold_req) begin
        stale_d = 1'b1;
      end else begin
        addr_d  = redir_addr;
        stale_d = 1'b0;
      end
    end else begin
      if (drop) discard_d = discard_d - OW'(1);
      if (gnt_fire) begin
        if (stale_q) begin
          discard_d = discard_d + OW'(1);
          addr_d    = restart_q;
        end else begin
          addr_d    = addr_q + ADDR_W'(4);
        end
        stale_d = 1'b0;
      end
    end
  end

  // Response FIFO: flushed on redirect, otherwise push/pop with a shared count.
  always_comb begin
    fifo_d  = fifo_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (redir) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        fifo_d[wr_q] = push_ent;
        wr_d = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control and pointer state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= BOOT_ADDR;
      pending_q <= 1'b0;
      stale_q   <= 1'b0;
      restart_q <= BOOT_ADDR;
      outst_q   <= '0;
      discard_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      pq_wr_q   <= '0;
      pq_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
      restart_q <= restart_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      pq_wr_q   <= pq_wr_d;
      pq_rd_q   <= pq_rd_d;
    end
  end

  // Storage arrays carry no reset; validity comes from the pointers and counts.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
    pcq_q  <= pcq_d;
  end

  // The credit rule must make a push into a full FIFO (without a matching pop) impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (count_q == CW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a bench-side memory, a stream-level reference model and literal checks.
// Latency: memory answers lat cycles after grant; every cycle's outputs are compared at the falling edge.
// Backpressure: grant and decode-ready are driven from the directed sequences.
module tb_if_fetch_queue;
  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic clk = 1'b0;
  logic rst;
  logic gnt_en;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  assign bus.instr_gnt_i = bus.instr_req_o & gnt_en;

  if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST),
                   .BOOT_ADDR(32'h80)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct { logic [31:0] addr; int tag; } gr_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mr_t;

  gr_t         grq[$];     // granted, unanswered fetches with the stream epoch they belong to
  ent_t        mq[$];      // what the decode-facing queue must hold
  mr_t         memq[$];    // responses the bench memory still owes
  logic [31:0] seen_pc[$];
  logic        seen_err[$];

  int          total = 0;
  int          bad = 0;
  int          epoch, req_tag, cyc = 0, lat, deliv;
  bit          halted, prev_req, prev_gnt, err_on;
  logic [31:0] prev_addr, exp_next, err_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return err_on && (a == err_addr);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model, advance the model, then drive memory for the next cycle.
  task automatic step();
    logic        req, gnt, valid;
    logic [31:0] addr;
    bit          held;
    gr_t         g;
    mr_t         m;
    ent_t        e;
    @(negedge clk);
    req   = bus.instr_req_o;
    gnt   = bus.instr_gnt_i;
    addr  = bus.instr_addr_o;
    valid = bus.f2d_valid_o;
    chk("f2d_valid", valid, mq.size() != 0);
    if (valid && mq.size() != 0) begin
      chk("f2d_pc", bus.f2d_pc_o, mq[0].pc);
      chk("f2d_instr", bus.f2d_instr_o, mq[0].instr);
      chk("f2d_err", bus.f2d_err_o, mq[0].err);
    end
    chk("busy", bus.busy_o, (mq.size() != 0) || (grq.size() != 0));
    held = prev_req && !prev_gnt;
    if (held) begin
      chk("req_hold", req, 1);
      chk("addr_hold", addr, prev_addr);
    end else if (req) begin
      req_tag = epoch;
      chk("addr_seq", addr, exp_next);
      chk("credit", (mq.size() + grq.size() < DEPTH) && (grq.size() < MAX_OUTST), 1);
      chk("req_while_halted", halted, 0);
      chk("req_while_disabled", bus.fetch_en_i, 1);
    end
    if (req && gnt) begin
      g.addr = addr; g.tag = req_tag; grq.push_back(g);
      m.addr = addr; m.due = cyc + lat; memq.push_back(m);
      if (req_tag == epoch) exp_next = addr + 32'd4;
    end
    if (valid && bus.f2d_ready_i && !bus.redirect_i && mq.size() != 0) begin
      seen_pc.push_back(bus.f2d_pc_o);
      seen_err.push_back(bus.f2d_err_o);
      void'(mq.pop_front());
      deliv++;
    end
    if (bus.redirect_i) begin
      mq.delete();
      epoch++;
      exp_next = {bus.redirect_addr_i[31:2], 2'b00};
      halted = 0;
    end
    if (bus.instr_rvalid_i && grq.size() != 0) begin
      g = grq.pop_front();
      if (g.tag == epoch) begin
        e.pc = g.addr; e.instr = mem_word(g.addr); e.err = mem_err(g.addr);
        mq.push_back(e);
        if (e.err) halted = 1;
      end
    end
    prev_req = req; prev_gnt = gnt; prev_addr = addr;
    @(posedge clk);
    #1;
    cyc++;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      bus.instr_rvalid_i = 1'b1;
      bus.instr_rdata_i  = mem_word(m.addr);
      bus.instr_err_i    = mem_err(m.addr);
    end else begin
      bus.instr_rvalid_i = 1'b0;
      bus.instr_rdata_i  = '0;
      bus.instr_err_i    = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fetch_en_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_addr_i = '0;
    bus.instr_rvalid_i = 1'b0; bus.instr_rdata_i = '0; bus.instr_err_i = 1'b0;
    bus.f2d_ready_i = 1'b1; gnt_en = 1'b1; lat = 1; err_on = 0; err_addr = '0;
    grq.delete(); mq.delete(); memq.delete(); seen_pc.delete(); seen_err.delete();
    epoch = 0; req_tag = 0; halted = 0; prev_req = 0; prev_gnt = 0; prev_addr = '0;
    exp_next = 32'h80; deliv = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus.instr_req_o, 0);
    chk("rst_addr", bus.instr_addr_o, 32'h80);
    chk("rst_valid", bus.f2d_valid_o, 0);
    chk("rst_pc", bus.f2d_pc_o, 0);
    chk("rst_instr", bus.f2d_instr_o, 0);
    chk("rst_err", bus.f2d_err_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    bus.redirect_i = 1'b1;
    bus.redirect_addr_i = a;
    step();
    bus.redirect_i = 1'b0;
  endtask

  task automatic wait_seen(input int n, input int limit, input string nm);
    int k = 0;
    while (seen_pc.size() < n && k < limit) begin
      step();
      k++;
    end
    chk(nm, seen_pc.size() >= n, 1);
  endtask

  initial begin
    int          d0;
    int          k;
    logic        found_err;
    logic [31:0] exp_pc;

    // 1: streaming with a one-cycle memory and an always-ready decoder
    do_reset();
    bus.fetch_en_i = 1'b1;
    repeat (6) step();
    d0 = deliv;
    repeat (8) step();
    chk("t1_throughput", deliv - d0, 8);
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h80 + 32'(4 * i);
      chk("t1_pc_order", seen_pc[i], exp_pc);
    end

    // 2: decoder stalled long enough to fill the buffer
    do_reset();
    bus.fetch_en_i = 1'b1;
    bus.f2d_ready_i = 1'b0;
    repeat (20) step();
    chk("t2_req_blocked", bus.instr_req_o, 0);
    chk("t2_valid_held", bus.f2d_valid_o, 1);
    chk("t2_head_pc", bus.f2d_pc_o, 32'h80);
    bus.fetch_en_i = 1'b0;
    bus.f2d_ready_i = 1'b1;
    repeat (8) step();
    chk("t2_count", seen_pc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h80 + 32'(4 * i);
      chk("t2_pc_order", seen_pc[i], exp_pc);
    end

    // 3: redirect while two fetches are in flight
    do_reset();
    lat = 3;
    bus.fetch_en_i = 1'b1;
    k = 0;
    while (grq.size() != 2 && k < 20) begin
      step();
      k++;
    end
    chk("t3_two_outstanding", grq.size(), 2);
    seen_pc.delete(); seen_err.delete();
    redirect_to(32'h1003);
    chk("t3_empty_after_redirect", bus.f2d_valid_o, 0);
    wait_seen(1, 30, "t3_resume_timeout");
    chk("t3_first_pc", seen_pc[0], 32'h1000);

    // 4: bus error on 0x88 halts fetching until a redirect
    do_reset();
    err_on = 1; err_addr = 32'h88;
    bus.fetch_en_i = 1'b1;
    repeat (15) step();
    found_err = 1'b0;
    foreach (seen_pc[i]) if (seen_pc[i] == 32'h88) found_err = seen_err[i];
    chk("t4_err_flag", found_err, 1);
    chk("t4_delivered", seen_pc.size(), 4);
    chk("t4_no_req", bus.instr_req_o, 0);
    err_on = 0;
    seen_pc.delete(); seen_err.delete();
    redirect_to(32'h200);
    wait_seen(1, 20, "t4_resume_timeout");
    chk("t4_resume_pc", seen_pc[0], 32'h200);

    // 5: grant withheld, then fetch disabled while the request is pending
    do_reset();
    gnt_en = 1'b0;
    bus.fetch_en_i = 1'b1;
    repeat (6) step();
    chk("t5_req_pending", bus.instr_req_o, 1);
    chk("t5_addr_pending", bus.instr_addr_o, 32'h80);
    bus.fetch_en_i = 1'b0;
    repeat (3) step();
    chk("t5_req_kept", bus.instr_req_o, 1);
    chk("t5_addr_kept", bus.instr_addr_o, 32'h80);
    gnt_en = 1'b1;
    step();
    k = 0;
    while (bus.busy_o && k < 10) begin
      step();
      k++;
    end
    chk("t5_busy_fall", bus.busy_o, 0);
    chk("t5_idle_no_req", bus.instr_req_o, 0);
    chk("t5_one_word", seen_pc.size(), 1);
    chk("t5_word_pc", seen_pc[0], 32'h80);

    // 6: address wraps past the top of the space
    do_reset();
    bus.fetch_en_i = 1'b1;
    redirect_to(32'hFFFF_FFFC);
    wait_seen(2, 30, "t6_timeout");
    chk("t6_top_pc", seen_pc[0], 32'hFFFF_FFFC);
    chk("t6_wrap_pc", seen_pc[1], 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
